// File: rtl/truth_table_sweep_ctrl.sv
// Truth-table characterisation sequencer: walks every input vector of an N-input gate,
// samples its (possibly asynchronous) output after a settle interval and scores it.
module truth_table_sweep_ctrl #(
  parameter int                   N_IN          = 3,
  parameter logic [(1<<N_IN)-1:0] EXPECTED      = 8'hF4,
  parameter int                   SETTLE_CYCLES = 4,
  parameter int                   SYNC_STAGES   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   captured,
  output logic [N_IN:0]          fail_count,
  output logic [N_IN-1:0]        first_fail_idx
);

  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [7:0]      cnt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   sync_d;
  logic                   sample;
  logic [N_IN-1:0]        pos;

  // Tables are stored MSB-first, so vector k lives at bit 2^N_IN-1-k, i.e. ~k.
  assign pos    = ~idx;
  assign sync_d = {sync_q, dut_out};
  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d[SYNC_STAGES-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      captured       <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        // Partial results are deliberately left in place for post-mortem inspection.
        state  <= IDLE;
        busy   <= 1'b0;
        dut_in <= '0;
        pass   <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              captured       <= '0;
              fail_count     <= '0;
              first_fail_idx <= '0;
              pass           <= 1'b0;
              idx            <= '0;
              dut_in         <= '0;
              cnt            <= '0;
              busy           <= 1'b1;
              state          <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              state <= SAMPLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SAMPLE: begin
            captured[pos] <= sample;
            if (sample != EXPECTED[pos]) begin
              fail_count <= fail_count + 1'b1;
              if (fail_count == '0) begin
                first_fail_idx <= idx;
              end
            end
            if (idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              idx    <= idx + 1'b1;
              dut_in <= idx + 1'b1;
              state  <= SETTLE;
            end
          end
          DONE: begin
            done   <= 1'b1;
            pass   <= (fail_count == '0);
            busy   <= 1'b0;
            dut_in <= '0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
